forward_ctrl: RTL and testbench
===============================

Name: forward_ctrl

Overview:
- Producer side of the 2-bit operand-select interface that drives the operand Mux3 instances (ForwardA/ForwardB) in the pipelined core.
- Keeps its own shadow of the EX, MEM and WB stage destination and source fields. From these it generates the forwarding selects for the EX-stage operands, plus a load-use Stall that freezes IF/ID and inserts a bubble into EX.
- Sits beside the decode stage and is clocked with the datapath pipeline registers.

Parameters:
- REG_ADDR_W, 5, register index width.
- X0_ZERO, 1, when 1 register index 0 never matches for forwarding or stall.
- CNT_W, 16, width of the stall performance counter.

Ports:
- Clk  in  1  core clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- IdRs1  in  REG_ADDR_W  rs1 index of the instruction in ID.
- IdRs2  in  REG_ADDR_W  rs2 index of the instruction in ID.
- IdRs1Used  in  1  the instruction in ID reads rs1.
- IdRs2Used  in  1  the instruction in ID reads rs2.
- IdRd  in  REG_ADDR_W  rd index of the instruction in ID.
- IdRegWrite  in  1  the instruction in ID writes rd.
- IdMemRead  in  1  the instruction in ID is a load.
- Flush  in  1  taken branch/jump resolved in EX; kills the instruction in ID.
- ForwardA  out  2  select for operand-A Mux3.
- ForwardB  out  2  select for operand-B Mux3.
- Stall  out  1  hold PC and IF/ID; insert bubble into EX.
- StallCount  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock and reset: one clock Clk. Reset is asynchronous and active-high.
- Reset state:
  - EX, MEM and WB records all invalid, all fields 0.
  - ForwardA = ForwardB = 2'b00, Stall = 0, StallCount = 0.
- Select encoding (fixed, must match the Mux3 input wiring):
  - 00 = register-file value (Input0).
  - 01 = WB-stage write data (Input1).
  - 10 = MEM-stage ALU result (Input2).
  - 11 is never driven.
- Stage record contents: valid, rs1, rs2, rs1used, rs2used, rd, regwrite, memread.
- Advance, every rising edge when not in reset:
  - WB <= MEM.
  - MEM <= EX (MEM and WB never stall).
  - EX <= bubble (valid=0, all else 0) if Flush or Stall; otherwise EX <= the ID fields with valid=1.
- Flush and Stall in the same cycle: Flush has priority in effect (EX gets a bubble either way), and StallCount is still incremented because Stall was asserted.
- Forward select, computed combinationally from registered state only (no ID inputs), so it is glitch-free relative to ID changes:
  - ForwardA = 10 if MEM.valid & MEM.regwrite & ~MEM.memread & MEM.rd==EX.rs1 & EX.rs1used & ~(X0_ZERO & EX.rs1==0).
  - Otherwise ForwardA = 01 if the same conditions hold on the WB record (memread allowed in WB).
  - Otherwise ForwardA = 00.
  - ForwardB is identical using rs2.
  - MEM has priority over WB (youngest producer wins).
- Load in MEM matching an EX source cannot occur, because the stall guarantees it. Bench asserts it never happens.
- Stall, combinational:
  - Stall = EX.valid & EX.memread & EX.regwrite & ((IdRs1Used & IdRs1==EX.rd) | (IdRs2Used & IdRs2==EX.rd)), gated by rd!=0 when X0_ZERO.
  - Stall lasts exactly one cycle per load-use pair, because the bubble clears EX.memread.
- Register-file write/read in the same cycle is resolved by the write-first regfile, not by this block. No third forwarding level.
- StallCount increments on each cycle with Stall=1 and saturates at all-ones.
- Reset mid-operation: all records clear immediately (asynchronous); outputs return to reset values in the same cycle.

Decomposition:
- Shared package core_pkg:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - stage_rec_t packed struct (fields listed above).
  - BUBBLE constant of type stage_rec_t.
- One natural sub-module: fwd_match, a combinational compare of one record against one source index, returning a hit. Instantiated four times for forwarding; the stall compare reuses it.

Test Plan:
- Back-to-back ALU dependency: ADD x5 in ID, then SUB reading rs1=x5 → on the cycle SUB is in EX, ForwardA=10; ForwardB=00 for its unrelated rs2.
- Distance-2 dependency: x7 written, one unrelated instruction, then reader of rs2=x7 → ForwardB=01 in the reader's EX cycle.
- Double hit: MEM.rd=WB.rd=x3, EX reads x3 on both operands → ForwardA=ForwardB=10.
- Load-use: LW x4 in EX, ID reads x4 via rs1 → Stall=1 for exactly 1 cycle, EX holds bubble next cycle, then ForwardA=01 when the consumer reaches EX; StallCount=1.
- x0 and unused source: producer rd=0 with consumer rs1=0, then consumer with rs1Used=0 matching rd=6 → ForwardA=00 and Stall=0 in both cases.
- Flush during stall, then reset: Flush=1 together with a load-use hit → EX bubble, StallCount increments. Then assert Reset mid-stream → outputs return to 00/0/0 within the same cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared pipeline-control types: operand-select encoding and the per-stage
// record that forward_ctrl shadows for EX, MEM and WB.
package core_pkg;

  // Record fields are sized to the widest register index the core uses.
  localparam int unsigned RA_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            rs1used;
    logic            rs2used;
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// Compares one stage record's destination against one source index; hit when
// that stage will write the register the source reads.
module fwd_match
  import core_pkg::*;
#(
  parameter bit X0_ZERO = 1'b1
) (
  input  logic            valid_i,
  input  logic            regwrite_i,
  input  logic [RA_W-1:0] rd_i,
  input  logic [RA_W-1:0] src_i,
  input  logic            src_used_i,
  output logic            hit_o
);

  logic x0_block;

  assign x0_block = X0_ZERO && (src_i == '0);
  assign hit_o    = valid_i && regwrite_i && src_used_i && (rd_i == src_i) && !x0_block;

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding-select and load-use stall generator; shadows the EX/MEM/WB
// register fields and advances them alongside the datapath pipeline.
module forward_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          X0_ZERO    = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] IdRs1,
  input  logic [REG_ADDR_W-1:0] IdRs2,
  input  logic                  IdRs1Used,
  input  logic                  IdRs2Used,
  input  logic [REG_ADDR_W-1:0] IdRd,
  input  logic                  IdRegWrite,
  input  logic                  IdMemRead,
  input  logic                  Flush,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  Stall,
  output logic [CNT_W-1:0]      StallCount
);

  stage_rec_t ex_q, ex_d, mem_q, wb_q, id_rec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mem_a_hit, mem_b_hit, wb_a_hit, wb_b_hit, ld_a_hit, ld_b_hit;
  logic stall;
  fwd_sel_e fwd_a, fwd_b;

  always_comb begin
    id_rec          = BUBBLE;
    id_rec.valid    = 1'b1;
    id_rec.rs1      = RA_W'(IdRs1);
    id_rec.rs2      = RA_W'(IdRs2);
    id_rec.rs1used  = IdRs1Used;
    id_rec.rs2used  = IdRs2Used;
    id_rec.rd       = RA_W'(IdRd);
    id_rec.regwrite = IdRegWrite;
    id_rec.memread  = IdMemRead;
  end

  fwd_match #(.X0_ZERO(X0_ZERO)) u_mem_a (
    .valid_i(mem_q.valid), .regwrite_i(mem_q.regwrite), .rd_i(mem_q.rd),
    .src_i(ex_q.rs1), .src_used_i(ex_q.rs1used), .hit_o(mem_a_hit)
  );
  fwd_match #(.X0_ZERO(X0_ZERO)) u_mem_b (
    .valid_i(mem_q.valid), .regwrite_i(mem_q.regwrite), .rd_i(mem_q.rd),
    .src_i(ex_q.rs2), .src_used_i(ex_q.rs2used), .hit_o(mem_b_hit)
  );
  fwd_match #(.X0_ZERO(X0_ZERO)) u_wb_a (
    .valid_i(wb_q.valid), .regwrite_i(wb_q.regwrite), .rd_i(wb_q.rd),
    .src_i(ex_q.rs1), .src_used_i(ex_q.rs1used), .hit_o(wb_a_hit)
  );
  fwd_match #(.X0_ZERO(X0_ZERO)) u_wb_b (
    .valid_i(wb_q.valid), .regwrite_i(wb_q.regwrite), .rd_i(wb_q.rd),
    .src_i(ex_q.rs2), .src_used_i(ex_q.rs2used), .hit_o(wb_b_hit)
  );

  // Load-use: the same compare, with EX as producer and the ID sources as readers.
  fwd_match #(.X0_ZERO(X0_ZERO)) u_ld_a (
    .valid_i(ex_q.valid), .regwrite_i(ex_q.regwrite), .rd_i(ex_q.rd),
    .src_i(id_rec.rs1), .src_used_i(id_rec.rs1used), .hit_o(ld_a_hit)
  );
  fwd_match #(.X0_ZERO(X0_ZERO)) u_ld_b (
    .valid_i(ex_q.valid), .regwrite_i(ex_q.regwrite), .rd_i(ex_q.rd),
    .src_i(id_rec.rs2), .src_used_i(id_rec.rs2used), .hit_o(ld_b_hit)
  );

  assign stall = ex_q.memread && (ld_a_hit || ld_b_hit);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (mem_a_hit && !mem_q.memread) fwd_a = FWD_MEM;
    else if (wb_a_hit)               fwd_a = FWD_WB;
    if (mem_b_hit && !mem_q.memread) fwd_b = FWD_MEM;
    else if (wb_b_hit)               fwd_b = FWD_WB;
  end

  always_comb begin
    ex_d  = (Flush || stall) ? BUBBLE : id_rec;
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_q  <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      cnt_q <= cnt_d;
    end
  end

  // Source fields travel with MEM/WB for symmetry but only rd/regwrite are consumed there.
  logic unused_fields;
  assign unused_fields = ^{mem_q.rs1, mem_q.rs2, mem_q.rs1used, mem_q.rs2used,
                           wb_q.rs1, wb_q.rs2, wb_q.rs1used, wb_q.rs2used, wb_q.memread};

  assign ForwardA   = fwd_a;
  assign ForwardB   = fwd_b;
  assign Stall      = stall;
  assign StallCount = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: dependency distances, x0/unused sources,
// load-use stall, flush, asynchronous reset and counter saturation.
module tb_forward_ctrl;

  localparam int unsigned CW = 3;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [4:0]    IdRs1, IdRs2, IdRd;
  logic          IdRs1Used, IdRs2Used, IdRegWrite, IdMemRead, Flush;
  logic [1:0]    ForwardA, ForwardB;
  logic          Stall;
  logic [CW-1:0] StallCount;

  int n_checks = 0;
  int n_fail   = 0;

  forward_ctrl #(.REG_ADDR_W(5), .X0_ZERO(1'b1), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .IdRs1(IdRs1), .IdRs2(IdRs2), .IdRs1Used(IdRs1Used), .IdRs2Used(IdRs2Used),
    .IdRd(IdRd), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .Flush(Flush),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Stall(Stall), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
    IdRs1 = rs1; IdRs2 = rs2; IdRs1Used = u1; IdRs2Used = u2;
    IdRd = rd; IdRegWrite = rw; IdMemRead = mr;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Flush = 1'b0; nop();
    step(); step();
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL reset_fa got=%b exp=00", ForwardA); end
    n_checks++; if (ForwardB !== 2'b00) begin n_fail++; $display("FAIL reset_fb got=%b exp=00", ForwardB); end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", Stall); end
    n_checks++; if (StallCount !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", StallCount); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);  // ADD x5
    step();
    drive(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);  // SUB x8, x5, x6
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%b exp=0", Stall); end
    step();
    n_checks++; if (ForwardA !== 2'b10) begin n_fail++; $display("FAIL b2b_fa got=%b exp=10", ForwardA); end
    n_checks++; if (ForwardB !== 2'b00) begin n_fail++; $display("FAIL b2b_fb got=%b exp=00", ForwardB); end
  endtask

  task automatic test_distance2();
    drive(5'd1, 5'd1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0);  // writes x7
    step();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);  // unrelated
    step();
    drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0); // reads x7 via rs2
    step();
    n_checks++; if (ForwardB !== 2'b01) begin n_fail++; $display("FAIL dist2_fb got=%b exp=01", ForwardB); end
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL dist2_fa got=%b exp=00", ForwardA); end
  endtask

  task automatic test_double_hit();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    drive(5'd2, 5'd1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    step();
    n_checks++; if (ForwardA !== 2'b10) begin n_fail++; $display("FAIL dbl_fa got=%b exp=10", ForwardA); end
    n_checks++; if (ForwardB !== 2'b10) begin n_fail++; $display("FAIL dbl_fb got=%b exp=10", ForwardB); end
  endtask

  task automatic test_load_use();
    drain();
    drive(5'd2, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);  // LW x4
    step();
    drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0); // consumer of x4
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%b exp=1", Stall); end
    n_checks++; if (StallCount !== 3'd0) begin n_fail++; $display("FAIL lu_cnt0 got=%0d exp=0", StallCount); end
    step();
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once got=%b exp=0", Stall); end
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_fa got=%b exp=00", ForwardA); end
    n_checks++; if (StallCount !== 3'd1) begin n_fail++; $display("FAIL lu_cnt1 got=%0d exp=1", StallCount); end
    step();
    n_checks++; if (ForwardA !== 2'b01) begin n_fail++; $display("FAIL lu_fa_wb got=%b exp=01", ForwardA); end
    n_checks++; if (ForwardA === 2'b10) begin n_fail++; $display("FAIL lu_mem_load_fwd got=%b exp=not 10", ForwardA); end
  endtask

  task automatic test_x0_unused();
    drain();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);  // writes x0
    step();
    drive(5'd0, 5'd2, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0);
    step();
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL x0_fa got=%b exp=00", ForwardA); end
    drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);  // LW x0
    step();
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0);
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL x0_stall got=%b exp=0", Stall); end
    drain();
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);  // writes x6
    step();
    drive(5'd6, 5'd1, 1'b0, 1'b1, 5'd15, 1'b1, 1'b0); // rs1=x6 but unused
    step();
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL unused_fa got=%b exp=00", ForwardA); end
    drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);  // LW x6
    step();
    drive(5'd6, 5'd1, 1'b0, 1'b1, 5'd15, 1'b1, 1'b0);
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL unused_stall got=%b exp=0", Stall); end
    n_checks++; if (StallCount !== 3'd1) begin n_fail++; $display("FAIL unused_cnt got=%0d exp=1", StallCount); end
  endtask

  task automatic test_flush_reset();
    drain();
    drive(5'd2, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);  // LW x4
    step();
    drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
    Flush = 1'b1;
    #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall got=%b exp=1", Stall); end
    step();
    Flush = 1'b0;
    n_checks++; if (StallCount !== 3'd2) begin n_fail++; $display("FAIL flush_cnt got=%0d exp=2", StallCount); end
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL flush_bubble_fa got=%b exp=00", ForwardA); end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL flush_bubble_stall got=%b exp=0", Stall); end
    drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    step();
    drive(5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    step();
    n_checks++; if (ForwardA !== 2'b10) begin n_fail++; $display("FAIL pre_rst_fa got=%b exp=10", ForwardA); end
    #2 Reset = 1'b1;
    #1;
    n_checks++; if (ForwardA !== 2'b00) begin n_fail++; $display("FAIL rst_mid_fa got=%b exp=00", ForwardA); end
    n_checks++; if (ForwardB !== 2'b00) begin n_fail++; $display("FAIL rst_mid_fb got=%b exp=00", ForwardB); end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got=%b exp=0", Stall); end
    n_checks++; if (StallCount !== 3'd0) begin n_fail++; $display("FAIL rst_mid_cnt got=%0d exp=0", StallCount); end
    nop();
    step();
    Reset = 1'b0;
    step();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    for (int i = 0; i < 9; i++) begin
      drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
      step();
      drive(5'd0, 5'd4, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0);  // hit via rs2
      #1;
      n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall[%0d] got=%b exp=1", i, Stall); end
      step();
      exp_cnt = (i + 1 > 7) ? 7 : i + 1;
      n_checks++; if (StallCount !== 3'(exp_cnt)) begin n_fail++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, StallCount, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_double_hit();
    test_load_use();
    test_x0_unused();
    test_flush_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
